// File: rtl/log2_table_arbiter_if.sv
// Requester-side and log2-unit-side handshake bundle for log2_table_arbiter.
// The arbiter uses the slave view; the surrounding environment uses master.
interface log2_table_arbiter_if #(
    parameter int BITS = 32,
    parameter int N    = 4
);
    logic [N-1:0]      req_valid;
    logic [N*BITS-1:0] req_a;
    logic [N-1:0]      req_ready;
    logic              unit_in_valid;
    logic [BITS-1:0]   unit_a;
    logic              unit_out_valid;
    logic [BITS-1:0]   unit_c;
    logic [N-1:0]      res_valid;
    logic [BITS-1:0]   res_c;

    modport master (
        output req_valid, req_a, unit_out_valid, unit_c,
        input  req_ready, unit_in_valid, unit_a, res_valid, res_c
    );

    modport slave (
        input  req_valid, req_a, unit_out_valid, unit_c,
        output req_ready, unit_in_valid, unit_a, res_valid, res_c
    );
endinterface

// File: rtl/log2_table_arbiter.sv
// Round-robin sharing of one in-order, fixed-latency log2 unit among N requesters;
// a tag FIFO remembers who issued each in-flight operation so its result is routed back.
module log2_table_arbiter #(
    parameter int BITS         = 32,
    parameter int N            = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    log2_table_arbiter_if.slave           bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_underflow
);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_INFLIGHT);
    localparam logic [PW:0]   N_COUNT   = (PW+1)'(N);
    localparam logic [PW-1:0] LAST_REQ  = PW'(N - 1);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW:0]     scan_sum;
    logic            found;
    logic            can_issue;
    logic            push;
    logic            pop;
    logic [N-1:0]    ready_vec;

    logic [PW-1:0]   tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            in_valid_q;
    logic [BITS-1:0] a_q;
    logic [N-1:0]    res_valid_q;
    logic [BITS-1:0] res_c_q;

    // Scan ptr, ptr+1, ... wrapping at N; the first valid requester wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= N_COUNT) begin
                scan_sum = scan_sum - N_COUNT;
            end
            if (!found && bus.req_valid[scan_sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan_sum[PW-1:0];
            end
        end
    end

    // A full FIFO may still accept when a pop frees a slot in the same cycle.
    always_comb begin
        can_issue = (inflight < MAX_COUNT) ||
                    ((inflight == MAX_COUNT) && bus.unit_out_valid);
        push      = found && can_issue;
        pop       = bus.unit_out_valid && (inflight != '0);
        ready_vec = '0;
        if (push) begin
            ready_vec[winner] = 1'b1;
        end
    end

    assign bus.req_ready     = ready_vec;
    assign bus.unit_in_valid = in_valid_q;
    assign bus.unit_a        = a_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_c         = res_c_q;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            inflight      <= '0;
            in_valid_q    <= 1'b0;
            a_q           <= '0;
            res_valid_q   <= '0;
            res_c_q       <= '0;
            err_underflow <= 1'b0;
        end else begin
            in_valid_q <= push;
            if (push) begin
                a_q    <= bus.req_a[winner*BITS +: BITS];
                wr_ptr <= wr_ptr + 1'b1;
                ptr    <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
            end

            if (pop) begin
                res_valid_q <= N'(1) << tag_mem[rd_ptr];
                res_c_q     <= bus.unit_c;
                rd_ptr      <= rd_ptr + 1'b1;
            end else begin
                res_valid_q <= '0;
            end

            if (bus.unit_out_valid && (inflight == '0)) begin
                err_underflow <= 1'b1;
            end

            case ({push, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_log2_table_arbiter.sv
// Directed bench for log2_table_arbiter: a 3-stage log2 unit stand-in, a queue-based
// ownership model checked every cycle, and literal expectations for each scenario.
module tb_log2_table_arbiter;
    localparam int BITS = 32;
    localparam int N    = 4;
    localparam int MAXI = 8;
    localparam int L    = 3;

    logic clk = 1'b0;
    logic reset;
    logic [$clog2(MAXI):0] inflight;
    logic err_underflow;

    always #5 clk = ~clk;

    log2_table_arbiter_if #(.BITS(BITS), .N(N)) bus ();

    log2_table_arbiter #(.BITS(BITS), .N(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Unit stand-in: exact log2 of powers of two, fixed latency L, or manual drive.
    logic        auto_mode;
    logic        man_valid;
    logic [31:0] man_c;
    logic        pipe_v [L];
    logic [31:0] pipe_c [L];

    function automatic logic [31:0] int_to_float(int v);
        int p;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if ((v >> i) != 0) p = i;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] log2_of(logic [31:0] a);
        return int_to_float(int'(a[30:23]) - 127);
    endfunction

    always @(posedge clk) begin
        if (reset || !auto_mode) begin
            for (int i = 0; i < L; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_c[i] <= 32'h0;
            end
        end else begin
            pipe_v[0] <= bus.unit_in_valid;
            pipe_c[0] <= log2_of(bus.unit_a);
            for (int i = 1; i < L; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_c[i] <= pipe_c[i-1];
            end
        end
    end

    assign bus.unit_out_valid = auto_mode ? pipe_v[L-1] : man_valid;
    assign bus.unit_c         = auto_mode ? pipe_c[L-1] : man_c;

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: owner queue, RR pointer, and the expected registered outputs.
    bit          model_known = 1'b0;
    int          model_ptr;
    int          owner_q[$];
    logic        exp_in_valid;
    logic [31:0] exp_a;
    logic [N-1:0] exp_res_valid;
    logic [31:0] exp_res_c;
    logic        exp_err;
    logic [N-1:0] m_ready;
    logic [N-1:0] m_rv;
    int          m_w;
    int          m_t;
    bit          m_ok;

    int          grant_log[$];
    int          res_owner_log[$];
    logic [31:0] res_c_log[$];

    always @(negedge clk) begin
        if (model_known) begin
            m_ok = (owner_q.size() < MAXI) || ((owner_q.size() == MAXI) && bus.unit_out_valid);
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                m_rv = bus.req_valid >> ((model_ptr + k) % N);
                if (m_w < 0 && m_rv[0]) m_w = (model_ptr + k) % N;
            end
            m_ready = (m_ok && m_w >= 0) ? (N'(1) << m_w) : '0;

            checkOutput("req_ready", 32'(bus.req_ready), 32'(m_ready));
            checkOutput("unit_in_valid", 32'(bus.unit_in_valid), 32'(exp_in_valid));
            checkOutput("unit_a", bus.unit_a, exp_a);
            checkOutput("res_valid", 32'(bus.res_valid), 32'(exp_res_valid));
            checkOutput("res_c", bus.res_c, exp_res_c);
            checkOutput("inflight", 32'(inflight), 32'(owner_q.size()));
            checkOutput("err_underflow", 32'(err_underflow), 32'(exp_err));

            for (int i = 0; i < N; i++) begin
                m_rv = (bus.req_valid & bus.req_ready) >> i;
                if (m_rv[0]) grant_log.push_back(i);
                m_rv = bus.res_valid >> i;
                if (m_rv[0]) begin
                    res_owner_log.push_back(i);
                    res_c_log.push_back(bus.res_c);
                end
            end
        end

        if (reset) begin
            model_known   = 1'b1;
            model_ptr     = 0;
            owner_q.delete();
            exp_in_valid  = 1'b0;
            exp_a         = 32'h0;
            exp_res_valid = '0;
            exp_res_c     = 32'h0;
            exp_err       = 1'b0;
        end else if (model_known) begin
            if (bus.unit_out_valid && owner_q.size() > 0) begin
                m_t = owner_q.pop_front();
                exp_res_valid = N'(1) << m_t;
                exp_res_c     = bus.unit_c;
            end else begin
                exp_res_valid = '0;
                if (bus.unit_out_valid) exp_err = 1'b1;
            end
            if (m_ready != '0) begin
                owner_q.push_back(m_w);
                exp_in_valid = 1'b1;
                exp_a        = 32'(bus.req_a >> (m_w * BITS));
                model_ptr    = (m_w + 1) % N;
            end else begin
                exp_in_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [N-1:0] valid, logic [N*BITS-1:0] a);
        bus.req_valid = valid;
        bus.req_a     = a;
    endtask

    task automatic doReset();
        bus.req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clearLogs();
        grant_log.delete();
        res_owner_log.delete();
        res_c_log.delete();
    endtask

    task automatic waitIdle(int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (inflight == '0) break;
        end
        checkOutput("drain_inflight", 32'(inflight), 32'h0);
        step();
    endtask

    function automatic int logAt(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    localparam logic [N*BITS-1:0] OPS_1248 = {32'h41000000, 32'h40800000, 32'h40000000, 32'h3F800000};

    initial begin
        reset     = 1'b1;
        auto_mode = 1'b1;
        man_valid = 1'b0;
        man_c     = 32'h0;
        applyStimulus('0, '0);
        step();
        step();
        @(negedge clk);
        checkOutput("rst_inflight", 32'(inflight), 32'h0);
        checkOutput("rst_err", 32'(err_underflow), 32'h0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'h0);
        checkOutput("rst_res_c", bus.res_c, 32'h0);
        checkOutput("rst_in_valid", 32'(bus.unit_in_valid), 32'h0);
        checkOutput("rst_unit_a", bus.unit_a, 32'h0);
        step();
        reset = 1'b0;

        $display("[TB] single requester");
        applyStimulus(4'b0001, {96'h0, 32'h40000000});
        @(negedge clk);
        checkOutput("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("t1_in_valid", 32'(bus.unit_in_valid), 32'h1);
        checkOutput("t1_unit_a", bus.unit_a, 32'h40000000);
        repeat (4) step();
        @(negedge clk);
        checkOutput("t1_res_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("t1_res_c", bus.res_c, 32'h3F800000);
        checkOutput("t1_inflight", 32'(inflight), 32'h0);

        $display("[TB] four requesters continuous");
        doReset();
        clearLogs();
        applyStimulus(4'b1111, OPS_1248);
        repeat (8) step();
        bus.req_valid = '0;
        waitIdle(30);
        checkOutput("t2_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("t2_grant%0d", i), 32'(logAt(grant_log, i)), 32'(i % 4));
        checkOutput("t2_res_count", 32'(res_owner_log.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_res_owner%0d", i), 32'(logAt(res_owner_log, i)), 32'(i));
            checkOutput($sformatf("t2_res_c%0d", i),
                        (i < res_c_log.size()) ? res_c_log[i] : 32'hFFFFFFFF,
                        (i == 0) ? 32'h0 : (i == 1) ? 32'h3F800000 :
                        (i == 2) ? 32'h40000000 : 32'h40400000);
        end

        $display("[TB] stalled unit");
        auto_mode = 1'b0;
        doReset();
        applyStimulus(4'b0001, {96'h0, 32'h40000000});
        repeat (8) step();
        @(negedge clk);
        checkOutput("t3_full_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("t3_full_inflight", 32'(inflight), 32'd8);
        step();
        @(negedge clk);
        checkOutput("t3_full_ready2", 32'(bus.req_ready), 32'h0);
        step();
        man_valid = 1'b1;
        man_c     = 32'h3F800000;
        @(negedge clk);
        checkOutput("t3_pop_ready", 32'(bus.req_ready), 32'h1);
        step();
        man_valid = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("t3_pop_inflight", 32'(inflight), 32'd8);
        checkOutput("t3_pop_res_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("t3_pop_res_c", bus.res_c, 32'h3F800000);
        auto_mode = 1'b1;
        doReset();

        $display("[TB] round-robin fairness");
        applyStimulus(4'b0011, OPS_1248);
        step();
        step();
        clearLogs();
        bus.req_valid = 4'b1011;
        repeat (3) step();
        bus.req_valid = '0;
        checkOutput("t4_grant_count", 32'(grant_log.size()), 32'd3);
        checkOutput("t4_grant0", 32'(logAt(grant_log, 0)), 32'd3);
        checkOutput("t4_grant1", 32'(logAt(grant_log, 1)), 32'd0);
        checkOutput("t4_grant2", 32'(logAt(grant_log, 2)), 32'd1);
        waitIdle(30);

        $display("[TB] underflow");
        auto_mode = 1'b0;
        man_valid = 1'b1;
        man_c     = 32'h12345678;
        @(negedge clk);
        checkOutput("t5_err_before", 32'(err_underflow), 32'h0);
        step();
        man_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_err_set", 32'(err_underflow), 32'h1);
        checkOutput("t5_res_valid", 32'(bus.res_valid), 32'h0);
        step();
        @(negedge clk);
        checkOutput("t5_err_held", 32'(err_underflow), 32'h1);
        auto_mode = 1'b1;
        doReset();
        @(negedge clk);
        checkOutput("t5_err_cleared", 32'(err_underflow), 32'h0);

        $display("[TB] reset with operations in flight");
        step();
        applyStimulus(4'b1111, OPS_1248);
        repeat (3) step();
        bus.req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_inflight_before", 32'(inflight), 32'd3);
        step();
        reset = 1'b0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        checkOutput("t6_inflight", 32'(inflight), 32'h0);
        checkOutput("t6_in_valid", 32'(bus.unit_in_valid), 32'h0);
        checkOutput("t6_res_valid", 32'(bus.res_valid), 32'h0);
        checkOutput("t6_first_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        waitIdle(30);
        checkOutput("t6_err", 32'(err_underflow), 32'h0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/log2_table_arbiter.md
Name: log2_table_arbiter

Overview:
- Shares one fixed-latency, pipelined log2 table unit (log2_table_one_to_two, PRECISION "SINGLE") between N independent requesters.
- Round-robin grant per cycle, with per-requester valid/ready handshake.
- A tag FIFO records the owner of each in-flight operation, so each result returns to the requester that issued it.
- Sits between the requesters and the log2 unit instance; the unit itself is instantiated outside this block.

Parameters:
- BITS, 32, operand/result width (single-precision float).
- N, 4, number of requesters (2..16).
- MAX_INFLIGHT, 8, tag FIFO depth and maximum outstanding operations (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  per-requester operand valid.
- req_a  input  N*BITS  operands; requester i occupies bits [i*BITS +: BITS].
- req_ready  output  N  per-requester accept, one-hot or zero.
- unit_in_valid  output  1  to log2 unit in_valid.
- unit_a  output  BITS  to log2 unit a.
- unit_out_valid  input  1  from log2 unit out_valid.
- unit_c  input  BITS  from log2 unit c.
- res_valid  output  N  one-hot result strobe for the owning requester.
- res_c  output  BITS  result value, shared by all requesters.
- inflight  output  $clog2(MAX_INFLIGHT)+1  outstanding operation count.
- err_underflow  output  1  sticky error: unit result arrived with the tag FIFO empty.

Behaviour:
- Reset values: unit_in_valid=0, unit_a=0, res_valid=0, res_c=0, inflight=0, err_underflow=0, RR pointer=0, FIFO empty.
- Reset asserted mid-operation discards all in-flight tags. Results the unit emits after reset are dropped and raise err_underflow. The integrator must reset the unit in the same cycle.

Grant (combinational):
- can_issue = (inflight < MAX_INFLIGHT) OR (inflight == MAX_INFLIGHT AND unit_out_valid).
- Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
- req_ready[winner] = can_issue. All other req_ready bits are 0.
- req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Transfer = req_valid[i] & req_ready[i].
- On transfer: ptr <= winner+1 mod N. With no transfer, ptr holds.

Issue path (registered, 1-cycle latency):
- On transfer: unit_in_valid <= 1, unit_a <= operand of the winner, and the winner index is pushed to the FIFO.
- With no transfer: unit_in_valid <= 0, unit_a holds.

Return path (registered, 1-cycle latency):
- On unit_out_valid with FIFO non-empty: pop tag t, res_valid <= one-hot(t), res_c <= unit_c.
- Otherwise res_valid <= 0 and res_c holds.
- unit_out_valid with FIFO empty: nothing is popped, res_valid stays 0, err_underflow <= 1. err_underflow clears only on reset.

Counter:
- inflight increments on push, decrements on pop, and is unchanged when both occur in the same cycle.
- Push while full is allowed only under the simultaneous-pop rule. The FIFO read/write pointers wrap modulo MAX_INFLIGHT.

Ordering and end-to-end timing:
- Results return in issue order, because the unit is in-order and fixed-latency.
- No backpressure on results. Requesters must accept res_valid on the cycle it is asserted.
- End-to-end latency: transfer cycle + 1 + unit latency + 1.

Test Plan:
- Single requester: req_valid[0]=1, req_a[0]=0x40000000 (2.0). Expect req_ready[0]=1 in that cycle, unit_in_valid one cycle later with unit_a=0x40000000. Expect res_valid=4'b0001 and res_c=0x3F800000 (1.0) at unit latency + 1 cycles later; inflight returns to 0.
- All four requesters valid continuously with operands 1.0, 2.0, 4.0, 8.0. Expect grants in order 0,1,2,3,0,... one per cycle. Expect res_valid in order 0001, 0010, 0100, 1000 with res_c = 0x00000000, 0x3F800000, 0x40000000, 0x40400000.
- Stalled unit model (out_valid held 0): issue 8 ops. Expect inflight=8 and all req_ready=0 on the 9th request until a result returns. In a cycle with unit_out_valid=1 and a request pending, expect the grant to occur and inflight to stay 8.
- RR fairness: ptr=2, req_valid=4'b1011. Expect grant to 3, then 0, then 1; requester 2 is never granted while idle.
- unit_out_valid pulsed with the FIFO empty: expect err_underflow=1 next cycle and held, res_valid=0. Assert reset: expect err_underflow=0.
- Reset asserted with 3 ops in flight: next cycle expect inflight=0, unit_in_valid=0, res_valid=0, ptr=0. A first new request goes to requester 0 when all are valid.
